// File: rtl/hw1_sweep_capture.sv
// Self-test sweeper for the 4-input hw1 cell: steps vec through every input code, captures fn_out into table_q and counts mismatches against EXPECTED.
// Optional macro SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatching vector instead of running to the end.
module hw1_sweep_capture #(
  parameter int                  N_IN          = 4,
  parameter int                  SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED      = 16'hA5C3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 fn_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_q,
  output logic [N_IN:0]        err_count,
  output logic                 pass
);

  localparam int W  = 2**N_IN;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    cap_q, cap_d;
  logic [N_IN:0]   err_q, err_d;
  logic            mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    err_d    = err_q;
    mismatch = (fn_out != EXPECTED[idx_q]);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          err_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        cap_d[idx_q] = fn_out;
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
        end
`ifdef SWEEP_STOP_ON_ERR_EN
        // A failing vector freezes idx so vec still shows the offending code.
        if (mismatch || idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
`else
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // vec always equals the vector index, so one register serves both.
  assign vec       = idx_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign table_q   = cap_q;
  assign err_count = err_q;
  assign pass      = done && (err_q == '0);

endmodule

// File: tb/tb_hw1_sweep_capture.sv
// Bench for hw1_sweep_capture: fixed vector table, hand-written corner sequences and random truth tables against a behavioural model.
module tb_hw1_sweep_capture;

  localparam int          N_IN = 4;
  localparam int          SC   = 2;
  localparam logic [15:0] EXP  = 16'hA5C3;
  localparam int          LAT  = 16 * (SC + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  vec;
  logic        fn_out;
  logic        busy;
  logic        done;
  logic [15:0] table_q;
  logic [4:0]  err_count;
  logic        pass;
  logic [15:0] cell_tt;

  int checks = 0;
  int errors = 0;

  assign fn_out = cell_tt[vec];

  hw1_sweep_capture #(
    .N_IN(N_IN),
    .SETTLE_CYCLES(SC),
    .EXPECTED(EXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vec(vec),
    .fn_out(fn_out),
    .busy(busy),
    .done(done),
    .table_q(table_q),
    .err_count(err_count),
    .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what a sweep of a cell with truth table tt must report.
  function automatic void model(input logic [15:0] tt, output logic [15:0] m_tab,
                                output int m_err, output int m_lat, output int m_vec);
    logic        found;
    logic [31:0] mask;
    m_tab = tt;
    m_err = 0;
    m_lat = LAT;
    m_vec = 15;
    found = 1'b0;
    mask  = '0;
    for (int i = 0; i < 16; i++) begin
      if (tt[i] != EXP[i]) begin
`ifdef SWEEP_STOP_ON_ERR_EN
        if (!found) begin
          found = 1'b1;
          mask  = (32'h1 << (i + 1)) - 32'h1;
          m_tab = tt & mask[15:0];
          m_err = 1;
          m_lat = (i + 1) * (SC + 1);
          m_vec = i;
        end
`else
        m_err++;
`endif
      end
    end
  endfunction

  // Call at #1 after a rising edge with the DUT in IDLE or DONE.
  task automatic run_sweep(input logic [15:0] tt, input int extra_at, output int lat,
                           output logic [15:0] tab, output int err, output logic ps,
                           output logic [3:0] v, output int busy_bad);
    cell_tt  = tt;
    start    = 1'b1;
    busy_bad = 0;
    lat      = -1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (!busy) busy_bad++;
      start = (c == extra_at);
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    tab   = table_q;
    err   = int'(err_count);
    ps    = pass;
    v     = vec;
  endtask

  typedef struct {
    logic [15:0] tt;
    logic [15:0] e_tab;
    int          e_err;
    logic        e_pass;
    int          e_lat;
    logic [3:0]  e_vec;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          lat, err, bb, gap, m_err, m_lat, m_vec;
    logic [15:0] tab, m_tab, tt;
    logic        ps;
    logic [3:0]  v;

`ifdef SWEEP_STOP_ON_ERR_EN
    tbl[0] = '{16'hA5C3, 16'hA5C3, 0, 1'b1, 48, 4'd15};
    tbl[1] = '{16'h0000, 16'h0000, 1, 1'b0,  3, 4'd0};
    tbl[2] = '{16'hFFFF, 16'h0007, 1, 1'b0,  9, 4'd2};
    tbl[3] = '{16'h5A3C, 16'h0000, 1, 1'b0,  3, 4'd0};
    tbl[4] = '{16'hA5C2, 16'h0000, 1, 1'b0,  3, 4'd0};
    tbl[5] = '{16'h25C3, 16'h25C3, 1, 1'b0, 48, 4'd15};
`else
    tbl[0] = '{16'hA5C3, 16'hA5C3,  0, 1'b1, 48, 4'd15};
    tbl[1] = '{16'h0000, 16'h0000,  8, 1'b0, 48, 4'd15};
    tbl[2] = '{16'hFFFF, 16'hFFFF,  8, 1'b0, 48, 4'd15};
    tbl[3] = '{16'h5A3C, 16'h5A3C, 16, 1'b0, 48, 4'd15};
    tbl[4] = '{16'hA5C2, 16'hA5C2,  1, 1'b0, 48, 4'd15};
    tbl[5] = '{16'h25C3, 16'h25C3,  1, 1'b0, 48, 4'd15};
`endif

    rst     = 1'b1;
    start   = 1'b0;
    cell_tt = EXP;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_vec", vec, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_table", table_q, 0);
    check("reset_err", err_count, 0);
    check("reset_pass", pass, 0);
    repeat (3) @(posedge clk);
    #1 check("idle_without_start", {busy, done, vec}, 0);

    for (int i = 0; i < 6; i++) begin
      run_sweep(tbl[i].tt, -1, lat, tab, err, ps, v, bb);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].e_lat);
      check($sformatf("tbl%0d_table", i), tab, tbl[i].e_tab);
      check($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      check($sformatf("tbl%0d_pass", i), ps, tbl[i].e_pass);
      check($sformatf("tbl%0d_vec", i), v, tbl[i].e_vec);
      check($sformatf("tbl%0d_busy_gaps", i), bb, 0);
      cell_tt = ~cell_tt;
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_frozen", i), {done, table_q, err_count, vec},
            {1'b1, tbl[i].e_tab, 5'(tbl[i].e_err), tbl[i].e_vec});
    end

    // Restart from DONE clears the previous results immediately.
    cell_tt = EXP;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_clears", {busy, done, table_q, err_count, vec}, {1'b1, 1'b0, 16'h0, 5'h0, 4'h0});
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
    end
    check("restart_pass", pass, 1);

    // Extra start pulse mid-sweep must be ignored.
    run_sweep(EXP, 20, lat, tab, err, ps, v, bb);
    check("midstart_latency", lat, LAT);
    check("midstart_pass", ps, 1);
    check("midstart_table", tab, EXP);

    // Reset in the middle of a sweep.
    cell_tt = EXP;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && vec != 4'd7; c++) begin
      @(posedge clk); #1;
    end
    check("reached_vec7", vec, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outputs", {vec, busy, done, table_q, err_count, pass}, 0);
    repeat (3) @(posedge clk);
    #1 check("midrst_stays_idle", {vec, busy, done}, 0);
    run_sweep(EXP, -1, lat, tab, err, ps, v, bb);
    check("midrst_restart_latency", lat, LAT);
    check("midrst_restart_pass", ps, 1);

    // start held high: one DONE cycle per re-sweep.
    cell_tt = EXP;
    start   = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("held%0d_pass", k), pass, 1);
      @(posedge clk); #1;
      check($sformatf("held%0d_done_one_cycle", k), done, 0);
      gap = 1;
      while (!done && gap < 200) begin
        @(posedge clk); #1;
        gap++;
      end
      check($sformatf("held%0d_period", k), gap, LAT + 1);
    end
    start = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 1) == 0) tt = 16'($urandom);
      else                           tt = EXP ^ (16'h1 << $urandom_range(0, 15));
      model(tt, m_tab, m_err, m_lat, m_vec);
      run_sweep(tt, -1, lat, tab, err, ps, v, bb);
      check($sformatf("rnd%0d_latency tt=%h", r, tt), lat, m_lat);
      check($sformatf("rnd%0d_table tt=%h", r, tt), tab, m_tab);
      check($sformatf("rnd%0d_err tt=%h", r, tt), err, m_err);
      check($sformatf("rnd%0d_pass tt=%h", r, tt), ps, (m_err == 0));
      check($sformatf("rnd%0d_vec tt=%h", r, tt), v, m_vec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
